// File: rtl/regfile_pkg.sv
// Shared defaults and clear-engine state encoding for the 2R1W register file.
package regfile_pkg;

  localparam int unsigned REGFILE_DATA_WIDTH = 8;
  localparam int unsigned REGFILE_REG_COUNT  = 16;

  typedef enum logic {
    RF_IDLE,
    RF_CLEAR
  } regfile_state_t;

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: same-cycle write bypass, zero-register masking, output flop.
// Bypass (write-first) is compiled in when REGFILE_BYPASS_EN is defined; read-first otherwise.
module regfile_read_port #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned ZERO_REG   = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] reg_value,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] value_c;

  // Zero-register masking is applied last so it wins over the bypass path.
  always_comb begin
    value_c = reg_value;
`ifdef REGFILE_BYPASS_EN
    if (write_en && (waddr == raddr)) value_c = wdata;
`endif
    if ((ZERO_REG != 0) && (raddr == '0)) value_c = '0;
  end

`ifndef REGFILE_BYPASS_EN
  logic unused_bypass_c;
  assign unused_bypass_c = ^{write_en, waddr, wdata};
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) rdata <= '0;
    else       rdata <= value_c;
  end

endmodule

// File: rtl/register_file_2r1w.sv
// 2-read/1-write register file with a one-entry-per-cycle sweep clear engine.
// Define REGFILE_BYPASS_EN for write-first reads; default is read-first.
module register_file_2r1w
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = REGFILE_DATA_WIDTH,
  parameter int unsigned REG_COUNT  = REGFILE_REG_COUNT,
  parameter int unsigned ADDR_WIDTH = $clog2(REG_COUNT),
  parameter int unsigned ZERO_REG   = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  input  logic [ADDR_WIDTH-1:0] raddr_b,
  output logic [DATA_WIDTH-1:0] rdata_b,
  input  logic                  clear_req,
  output logic                  clear_busy,
  output logic                  wr_drop
);

  regfile_state_t        state, next_state;
  logic [ADDR_WIDTH-1:0] clear_idx;
  logic [DATA_WIDTH-1:0] regs [REG_COUNT];
  logic                  write_en_c;
  logic                  drop_c;
  logic                  clear_last_c;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= RF_IDLE;
    else       state <= next_state;
  end

  // Writes are only accepted in IDLE; a load during the sweep is reported as dropped.
  always_comb begin
    next_state   = state;
    write_en_c   = 1'b0;
    drop_c       = 1'b0;
    clear_last_c = (clear_idx == ADDR_WIDTH'(REG_COUNT - 1));
    case (state)
      RF_IDLE: begin
        write_en_c = load && !((ZERO_REG != 0) && (waddr == '0));
        if (clear_req) next_state = RF_CLEAR;
      end
      RF_CLEAR: begin
        drop_c = load;
        if (clear_last_c) next_state = RF_IDLE;
      end
      default: next_state = RF_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clear_idx  <= '0;
      clear_busy <= 1'b0;
      wr_drop    <= 1'b0;
    end else begin
      clear_busy <= (next_state == RF_CLEAR);
      wr_drop    <= drop_c;
      if (state == RF_CLEAR) clear_idx <= clear_idx + ADDR_WIDTH'(1);
    end
  end

  // Sweep clear owns the write path while active.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(REG_COUNT); i++) regs[i] <= '0;
    end else if (state == RF_CLEAR) begin
      regs[clear_idx] <= '0;
    end else if (write_en_c) begin
      regs[waddr] <= wdata;
    end
  end

  regfile_read_port #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .ZERO_REG  (ZERO_REG)
  ) u_read_a (
    .clock    (clock),
    .reset    (reset),
    .raddr    (raddr_a),
    .reg_value(regs[raddr_a]),
    .write_en (write_en_c),
    .waddr    (waddr),
    .wdata    (wdata),
    .rdata    (rdata_a)
  );

  regfile_read_port #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .ZERO_REG  (ZERO_REG)
  ) u_read_b (
    .clock    (clock),
    .reset    (reset),
    .raddr    (raddr_b),
    .reg_value(regs[raddr_b]),
    .write_en (write_en_c),
    .waddr    (waddr),
    .wdata    (wdata),
    .rdata    (rdata_b)
  );

endmodule

// File: tb/tb_register_file_2r1w.sv
// Bench for register_file_2r1w: directed scenarios plus random traffic against an array model.
// Two instances share stimulus: ZERO_REG=0 and ZERO_REG=1. Honours REGFILE_BYPASS_EN.
module tb_register_file_2r1w;

  localparam int unsigned DW = 8;
  localparam int unsigned RC = 16;
  localparam int unsigned AW = 4;

  logic          clock = 1'b0;
  logic          reset, load, clear_req;
  logic [AW-1:0] waddr, raddr_a, raddr_b;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata_a [2];
  logic [DW-1:0] rdata_b [2];
  logic          clear_busy [2];
  logic          wr_drop [2];

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state: one array per instance, sweep tracked as busy flag + position.
  logic [DW-1:0] m [2][RC];
  bit            m_busy;
  int            m_pos;
  bit            m_drop;
  logic [DW-1:0] e_a [2];
  logic [DW-1:0] e_b [2];

  always #5 clock = ~clock;

  register_file_2r1w #(.DATA_WIDTH(DW), .REG_COUNT(RC), .ZERO_REG(0)) dut (
    .clock(clock), .reset(reset), .load(load), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(rdata_a[0]), .raddr_b(raddr_b), .rdata_b(rdata_b[0]),
    .clear_req(clear_req), .clear_busy(clear_busy[0]), .wr_drop(wr_drop[0])
  );

  register_file_2r1w #(.DATA_WIDTH(DW), .REG_COUNT(RC), .ZERO_REG(1)) dut_z (
    .clock(clock), .reset(reset), .load(load), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(rdata_a[1]), .raddr_b(raddr_b), .rdata_b(rdata_b[1]),
    .clear_req(clear_req), .clear_busy(clear_busy[1]), .wr_drop(wr_drop[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_read(input int k, input logic [AW-1:0] r);
    if (k == 1 && r == '0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (load && !m_busy && !(k == 1 && waddr == '0) && waddr == r) return wdata;
`endif
    return m[k][r];
  endfunction

  task automatic step_model();
    for (int k = 0; k < 2; k++) begin
      e_a[k] = model_read(k, raddr_a);
      e_b[k] = model_read(k, raddr_b);
    end
    m_drop = load && m_busy;
    if (m_busy) begin
      m[0][m_pos] = '0;
      m[1][m_pos] = '0;
      m_pos++;
      if (m_pos == int'(RC)) begin
        m_busy = 1'b0;
        m_pos  = 0;
      end
    end else begin
      if (load) begin
        m[0][waddr] = wdata;
        if (waddr != '0) m[1][waddr] = wdata;
      end
      if (clear_req) m_busy = 1'b1;
    end
  endtask

  task automatic tick();
    step_model();
    @(posedge clock);
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rdata_a[%0d]", k), 32'(rdata_a[k]), 32'(e_a[k]));
      check($sformatf("rdata_b[%0d]", k), 32'(rdata_b[k]), 32'(e_b[k]));
      check($sformatf("clear_busy[%0d]", k), 32'(clear_busy[k]), 32'(m_busy));
      check($sformatf("wr_drop[%0d]", k), 32'(wr_drop[k]), 32'(m_drop));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    for (int i = 0; i < int'(RC); i++) begin
      m[0][i] = '0;
      m[1][i] = '0;
    end
    m_busy = 1'b0;
    m_pos  = 0;
    for (int k = 0; k < 2; k++) begin
      check("reset rdata_a", 32'(rdata_a[k]), 32'd0);
      check("reset rdata_b", 32'(rdata_b[k]), 32'd0);
      check("reset clear_busy", 32'(clear_busy[k]), 32'd0);
      check("reset wr_drop", 32'(wr_drop[k]), 32'd0);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    load = 1'b1; waddr = a; wdata = d;
    tick();
    load = 1'b0;
  endtask

  task automatic fill_all();
    for (int i = 0; i < int'(RC); i++) write(AW'(i), DW'(8'h10 + i));
  endtask

  int busy_cycles;
  int drops;

  initial begin
    reset = 1'b1; load = 1'b0; clear_req = 1'b0;
    waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
    do_reset();

    // Basic write then dual read.
    write(4'd3, 8'hA5);
    write(4'd12, 8'h5A);
    raddr_a = 4'd3; raddr_b = 4'd12;
    tick();
    check("read A reg3", 32'(rdata_a[0]), 32'hA5);
    check("read B reg12", 32'(rdata_b[0]), 32'h5A);

    // Same-cycle write and read of reg 5.
    write(4'd5, 8'h11);
    raddr_a = 4'd5;
    write(4'd5, 8'h77);
`ifdef REGFILE_BYPASS_EN
    check("bypass reg5", 32'(rdata_a[0]), 32'h77);
`else
    check("read-first reg5", 32'(rdata_a[0]), 32'h11);
`endif
    tick();
    check("reg5 after write", 32'(rdata_a[0]), 32'h77);

    // Full sweep with a dropped write to reg 2 mid-sweep.
    fill_all();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    busy_cycles = 0;
    drops = 0;
    for (int i = 0; i < 40 && clear_busy[0]; i++) begin
      busy_cycles++;
      raddr_a = AW'(i);
      raddr_b = AW'(RC - 1 - i);
      if (i == 3) begin load = 1'b1; waddr = 4'd2; wdata = 8'hFF; end
      else load = 1'b0;
      tick();
      if (wr_drop[0]) drops++;
    end
    load = 1'b0;
    raddr_a = 4'd2;
    tick();
    if (wr_drop[0]) drops++;
    check("busy cycles", 32'(busy_cycles), 32'd16);
    check("drop pulses", 32'(drops), 32'd1);
    check("reg2 after sweep", 32'(rdata_a[0]), 32'd0);
    write(4'd7, 8'h3C);
    raddr_a = 4'd7;
    tick();
    check("write after sweep", 32'(rdata_a[0]), 32'h3C);

    // Reset in the middle of a sweep.
    fill_all();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    do_reset();
    for (int i = 0; i < int'(RC); i++) begin
      raddr_a = AW'(i); raddr_b = AW'(RC - 1 - i);
      tick();
      check("post-reset A zero", 32'(rdata_a[0]), 32'd0);
    end

    // Write to register 0: discarded silently only on the ZERO_REG instance.
    raddr_a = 4'd0; raddr_b = 4'd0;
    write(4'd0, 8'hCC);
    tick();
    check("zero reg A", 32'(rdata_a[1]), 32'd0);
    check("zero reg B", 32'(rdata_b[1]), 32'd0);
    check("zero reg no drop", 32'(wr_drop[1]), 32'd0);
    check("plain reg0", 32'(rdata_a[0]), 32'hCC);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      load      = 1'($urandom_range(0, 1));
      waddr     = AW'($urandom_range(0, RC - 1));
      wdata     = DW'($urandom);
      raddr_a   = AW'($urandom_range(0, RC - 1));
      raddr_b   = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, RC - 1));
      clear_req = ($urandom_range(0, 24) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/register_file_2r1w.md
# register_file_2r1w

Parametrised register file: DATA_WIDTH-bit words, REG_COUNT entries, two registered read ports and one write port. It adds a sequential clear engine that zeroes the array one entry per clock without asserting reset, and an optional hard-wired zero register. It succeeds the single-port 16x8 register unit in the datapath, feeding ALU operands A and B from one array while the writeback stage updates it.

## Interface
- DATA_WIDTH, 8, bits per register
- REG_COUNT, 16, number of registers (power of two, >= 2)
- ADDR_WIDTH, $clog2(REG_COUNT), address width (derived; do not override)
- ZERO_REG, 0, when 1, register 0 reads as 0 and writes to it are discarded
- clock  input  1  clock, all state on the rising edge
- reset  input  1  reset, asynchronous, active-high
- load  input  1  write request this cycle
- waddr  input  ADDR_WIDTH  write address
- wdata  input  DATA_WIDTH  write data
- raddr_a  input  ADDR_WIDTH  read port A address
- rdata_a  output  DATA_WIDTH  read port A data, registered
- raddr_b  input  ADDR_WIDTH  read port B address
- rdata_b  output  DATA_WIDTH  read port B data, registered
- clear_req  input  1  start a sweep clear (level sampled in IDLE)
- clear_busy  output  1  sweep clear in progress
- wr_drop  output  1  one-cycle pulse: the previous cycle's load was discarded

## Operation
- Reset: all registers = 0, rdata_a = rdata_b = 0, clear_busy = 0, wr_drop = 0, FSM = IDLE, clear index = 0.
- Write is accepted when load=1, FSM=IDLE, and not (ZERO_REG=1 and waddr=0). An accepted write sets reg[waddr] <= wdata at the edge.
- Write is dropped when load=1 and FSM=CLEAR. The array is unchanged and wr_drop=1 the next cycle. A write to register 0 with ZERO_REG=1 is discarded silently; wr_drop is not raised.
- Reads: each edge, rdata_x <= value(raddr_x). Both ports are independent, and the same address on both ports is legal.
- value(r) is reg[r], except:
  - ZERO_REG=1 and r=0: value is 0.
  - An accepted write to r in the same cycle: see Configuration.
- FSM:
  - IDLE -> CLEAR when clear_req=1. clear_req is ignored while in CLEAR.
  - In CLEAR, each cycle: reg[idx] <= 0, then idx <= idx+1.
  - CLEAR -> IDLE on the cycle that clears idx = REG_COUNT-1; idx wraps to 0.
  - clear_busy = (FSM == CLEAR).
- A load on the same cycle as the clear_req that starts CLEAR is accepted, because the FSM is still IDLE. Entry 0 is cleared on the following edge.
- Reads during CLEAR return current contents: already-cleared entries read 0, uncleared entries read their old value.
- reset mid-sweep aborts the sweep immediately: FSM = IDLE and all registers = 0.

## Timing
- Read latency is 1 cycle: an address presented before edge N gives data valid after edge N.
- Write-to-read: a read issued the cycle after an accepted write returns the new value.
- clear_busy rises one edge after clear_req is sampled and stays high for exactly REG_COUNT cycles.
- load is accepted again on the first cycle clear_busy=0.
- wr_drop is high for exactly one cycle per dropped write.

## Configuration
- REGFILE_BYPASS_EN defined: a read of address r in the same cycle as an accepted write to r returns wdata. This is write-first behaviour.
- REGFILE_BYPASS_EN undefined: that read returns the pre-write contents of reg[r]. This is read-first behaviour.
- ZERO_REG takes precedence over bypass: with ZERO_REG=1, register 0 always reads 0.

## Structure
- Shared package regfile_pkg holds:
  - default constants REGFILE_DATA_WIDTH=8 and REGFILE_REG_COUNT=16
  - FSM state enum regfile_state_t {RF_IDLE, RF_CLEAR}
- Sub-module regfile_read_port: one instance per port. It implements address compare, bypass mux, zero-register masking and the output register. The top module owns the array, write logic and clear FSM.

## Test plan
- Reset, then write 0xA5 to reg 3 and 0x5A to reg 12 → next cycle raddr_a=3, raddr_b=12 gives rdata_a=0xA5, rdata_b=0x5A.
- Write 0x77 to reg 5 while raddr_a=5, with reg 5 previously 0x11 → rdata_a=0x77 with REGFILE_BYPASS_EN, 0x11 without.
- Fill all 16 registers with 0x10+i, pulse clear_req → clear_busy high for 16 cycles. Reg 0..k read 0 during the sweep, reg k+1..15 still read 0x10+i. All read 0 afterwards.
- load=1 to reg 2 with 0xFF during CLEAR → wr_drop pulses once and reg 2 reads 0 after the sweep.
- Assert reset at cycle 5 of a sweep → clear_busy=0, rdata_a=rdata_b=0, and all registers read 0 afterwards.
- ZERO_REG=1: write 0xCC to reg 0 → both ports read 0 and wr_drop stays 0.
